// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: unsigned shift-add multiplier, one partial-product step per clock
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   multiplicand_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, q_q, q_d, acc_q, acc_d;
    logic               c_q, c_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               busy_q, busy_d, done_q, done_d;
    // next state: load on accept, add-then-shift {C,ACC,Q} each RUN cycle, capture product entering DONE
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        acc_d     = acc_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        sum       = q_q[0] ? {1'b0, acc_q} + {1'b0, a_q} : {1'b0, acc_q};
        case (state_q)
            IDLE: if (start_i) begin
                state_d = RUN;
                a_d     = multiplicand_i;
                q_d     = multiplier_i;
                acc_d   = '0;
                c_d     = 1'b0;
                cnt_d   = '0;
            end
            RUN: begin
                {c_d, acc_d, q_d} = {1'b0, sum, q_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == CW'(WIDTH)) begin
                    state_d   = DONE;
                    product_d = {acc_d, q_d};
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_q == RUN;
        done_d = state_q == DONE;
    end
    // state and registered outputs; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: scoreboard bench for WIDTH=8 and WIDTH=4 multipliers
module tb_seq_shift_add_multiplier;
    logic clk = 1'b0, rst = 1'b1;
    logic s8 = 1'b0, busy8, done8;
    logic [7:0] a8 = '0, b8 = '0;
    logic [15:0] p8;
    logic s4 = 1'b0, busy4, done4;
    logic [3:0] a4 = '0, b4 = '0;
    logic [7:0] p4;
    int vectors = 0, miscompares = 0;
    logic [15:0] exp8[$];
    logic [7:0]  exp4[$];

    seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(s8), .multiplicand_i(a8), .multiplier_i(b8),
        .busy_o(busy8), .done_o(done8), .product_o(p8));
    seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start_i(s4), .multiplicand_i(a4), .multiplier_i(b4),
        .busy_o(busy4), .done_o(done4), .product_o(p4));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do8(input logic [7:0] a, input logic [7:0] b);
        int lat;
        logic [15:0] e;
        s8 = 1'b1; a8 = a; b8 = b;
        exp8.push_back(16'(a) * 16'(b));
        tick;
        s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        while (!done8 && lat < 40) begin tick; lat++; end
        vectors++;
        if (lat !== 9) begin miscompares++; $display("FAIL lat8 %0d*%0d: got %0d want 9", a, b, lat); end
        e = exp8.pop_front();
        vectors++;
        if (p8 !== e) begin miscompares++; $display("FAIL prod8 %0d*%0d: got %0d want %0d", a, b, p8, e); end
    endtask

    task automatic do4(input logic [3:0] a, input logic [3:0] b);
        int lat;
        logic [7:0] e;
        s4 = 1'b1; a4 = a; b4 = b;
        exp4.push_back(8'(a) * 8'(b));
        tick;
        s4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        lat = 0;
        while (!done4 && lat < 40) begin tick; lat++; end
        vectors++;
        if (lat !== 5) begin miscompares++; $display("FAIL lat4 %0d*%0d: got %0d want 5", a, b, lat); end
        e = exp4.pop_front();
        vectors++;
        if (p4 !== e) begin miscompares++; $display("FAIL prod4 %0d*%0d: got %0d want %0d", a, b, p4, e); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        vectors++;
        if ({busy8, done8, p8} !== 18'd0) begin miscompares++; $display("FAIL reset8: got busy=%b done=%b prod=%0d want 0 0 0", busy8, done8, p8); end
        vectors++;
        if ({busy4, done4, p4} !== 10'd0) begin miscompares++; $display("FAIL reset4: got busy=%b done=%b prod=%0d want 0 0 0", busy4, done4, p4); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        int bad;
        logic [15:0] e;
        s8 = 1'b1; a8 = 8'd13; b8 = 8'd11;
        exp8.push_back(16'd143);
        tick;
        s8 = 1'b0;
        vectors++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin miscompares++; $display("FAIL basic_e0: got busy=%b done=%b want 0 0", busy8, done8); end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (busy8 !== 1'b1 || done8 !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL basic_busy: got %0d bad cycles want 0", bad); end
        tick;
        e = exp8.pop_front();
        vectors++;
        if (done8 !== 1'b1 || busy8 !== 1'b0 || p8 !== e) begin
            miscompares++; $display("FAIL basic_done: got done=%b busy=%b prod=%0d want 1 0 %0d", done8, busy8, p8, e);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (done8 !== 1'b0 || p8 !== 16'd143) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL basic_hold: got %0d bad cycles prod=%0d want 0 143", bad, p8); end
    endtask

    task automatic test_corners;
        do8(8'd255, 8'd255);
        do8(8'd0, 8'd200);
        do8(8'd200, 8'd0);
        do8(8'd1, 8'd255);
    endtask

    task automatic test_start_while_busy;
        int lat, nd;
        logic [15:0] e;
        s8 = 1'b1; a8 = 8'd13; b8 = 8'd11;
        exp8.push_back(16'd143);
        tick;
        s8 = 1'b0;
        repeat (3) tick;
        s8 = 1'b1; a8 = 8'd99; b8 = 8'd77;
        repeat (3) tick;
        s8 = 1'b0;
        lat = 6;
        while (!done8 && lat < 40) begin tick; lat++; end
        vectors++;
        if (lat !== 9) begin miscompares++; $display("FAIL busy_start_lat: got %0d want 9", lat); end
        e = exp8.pop_front();
        vectors++;
        if (p8 !== e) begin miscompares++; $display("FAIL busy_start_prod: got %0d want %0d", p8, e); end
        nd = 0;
        repeat (15) begin tick; if (done8 || busy8) nd++; end
        vectors++;
        if (nd != 0) begin miscompares++; $display("FAIL busy_start_extra: got %0d active cycles want 0", nd); end
    endtask

    task automatic test_back_to_back;
        int nd, last, overlap, first;
        logic [15:0] e;
        repeat (4) exp8.push_back(16'd15);
        s8 = 1'b1; a8 = 8'd3; b8 = 8'd5;
        nd = 0; last = -1; overlap = 0; first = -1;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (busy8 && done8) overlap++;
            if (done8) begin
                e = (exp8.size() > 0) ? exp8.pop_front() : 16'hxxxx;
                vectors++;
                if (p8 !== e) begin miscompares++; $display("FAIL b2b_prod #%0d: got %0d want %0d", nd, p8, e); end
                if (last >= 0) begin
                    vectors++;
                    if (i - last != 10) begin miscompares++; $display("FAIL b2b_period: got %0d want 10", i - last); end
                end else first = i;
                last = i;
                nd++;
            end
        end
        s8 = 1'b0;
        vectors++;
        if (first != 10) begin miscompares++; $display("FAIL b2b_first: got %0d want 10", first); end
        vectors++;
        if (nd != 4) begin miscompares++; $display("FAIL b2b_count: got %0d want 4", nd); end
        vectors++;
        if (overlap != 0) begin miscompares++; $display("FAIL b2b_overlap: got %0d want 0", overlap); end
        exp8.delete();
        tick;
    endtask

    task automatic test_reset_abort;
        int nd;
        s8 = 1'b1; a8 = 8'd100; b8 = 8'd100;
        tick;
        s8 = 1'b0;
        repeat (4) tick;
        vectors++;
        if (busy8 !== 1'b1) begin miscompares++; $display("FAIL abort_busy: got %b want 1", busy8); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        vectors++;
        if ({busy8, done8, p8} !== 18'd0) begin miscompares++; $display("FAIL abort_clear: got busy=%b done=%b prod=%0d want 0 0 0", busy8, done8, p8); end
        nd = 0;
        repeat (15) begin tick; if (done8 || busy8) nd++; end
        vectors++;
        if (nd != 0) begin miscompares++; $display("FAIL abort_quiet: got %0d active cycles want 0", nd); end
        do8(8'd7, 8'd9);
        rst = 1'b1; s8 = 1'b1; a8 = 8'd5; b8 = 8'd5;
        tick;
        rst = 1'b0; s8 = 1'b0;
        nd = 0;
        repeat (15) begin tick; if (done8 || busy8) nd++; end
        vectors++;
        if (nd != 0) begin miscompares++; $display("FAIL rst_prio: got %0d active cycles want 0", nd); end
    endtask

    task automatic test_width4;
        for (int i = 0; i < 256; i++) do4(4'(i >> 4), 4'(i));
        for (int i = 0; i < 200; i++) do4(4'($urandom), 4'($urandom));
    endtask

    initial begin
        test_reset;
        test_basic;
        test_corners;
        test_start_while_busy;
        test_back_to_back;
        test_reset_abort;
        test_width4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seq_shift_add_multiplier.md
# seq_shift_add_multiplier

Sequential unsigned shift-add multiplier that computes one partial-product step per clock. It is the control and accumulation stage wrapped around the bit-level adder cells (half/full adders forming a WIDTH-bit ripple adder). It accepts an operand pair on a start pulse, iterates WIDTH add/shift cycles, then presents a 2·WIDTH-bit product with a one-cycle done strobe.

## Interface
- WIDTH, 8, operand width in bits; legal range 2–32.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  in  1  request to begin a multiply; honoured only in IDLE.
- multiplicand  in  WIDTH  unsigned operand A; sampled on the accepting edge only.
- multiplier  in  WIDTH  unsigned operand B; sampled on the accepting edge only.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle strobe; product is valid and final.
- product  out  2·WIDTH  unsigned A·B; holds its value until the next accepted start.

## Operation
- Registers:
  - A: WIDTH bits, multiplicand.
  - Q: WIDTH bits, multiplier, shifted out LSB-first.
  - ACC: WIDTH bits.
  - C: 1-bit carry.
  - CNT: $clog2(WIDTH+1) bits.
  - state.
- States:
  - IDLE: waits for start. When start=1, load A=multiplicand, Q=multiplier, ACC=0, C=0, CNT=0, and go to RUN.
  - RUN: each cycle, if Q[0]=1 then {C,ACC} = ACC + A (WIDTH+1-bit sum); otherwise {C,ACC} = {0,ACC}. Then shift the 2·WIDTH+1-bit word {C,ACC,Q} right by 1 and set CNT = CNT+1. On the cycle where CNT reaches WIDTH (after the WIDTH-th step), go to DONE.
  - DONE: done=1 and product={ACC,Q}. Go to IDLE on the next edge unconditionally.
- product is a register loaded on entry to DONE. It is not driven from live ACC/Q. It keeps its value through IDLE and the next RUN until the following DONE.
- Arithmetic:
  - The addition uses unsigned WIDTH+1-bit precision and never overflows.
  - The final product is exact, including (2^WIDTH−1)².
  - C is always 0 after the shift.
- start while busy=1 or done=1 is ignored. It has no effect on operands or state.
- start held high continuously: a new multiply is accepted on the first IDLE cycle after each DONE.
- Operand inputs may change freely outside the accepting edge.

## Timing
- Reset values: state=IDLE, busy=0, done=0, product=0, ACC=0, Q=0, A=0, C=0, CNT=0.
- Accepting edge = edge E where state=IDLE and start=1.
  - busy=1 in the cycles after edges E+1 … E+WIDTH (WIDTH cycles).
  - done=1 for exactly one cycle, after edge E+WIDTH+1.
  - Latency from start sampled to done high is WIDTH+1 clocks.
- Throughput with start held high: one result every WIDTH+2 clocks (IDLE, WIDTH×RUN, DONE).
- busy and done are never high simultaneously.
- rst=1 mid-RUN or in DONE: the next edge forces every reset value, and done does not assert for the aborted operation. rst has priority over start on the same edge.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- WIDTH=8, reset, then start with A=13, B=11 → busy high for 8 cycles; done pulses 9 clocks after the accepting edge with product=143. product is still 143 ten cycles later.
- WIDTH=8, A=255, B=255 → product=65025 (0xFE01). Also A=0,B=200 → 0; A=200,B=0 → 0; A=1,B=255 → 255.
- Raise start 3 cycles into RUN with different operands → those operands are ignored; the first result completes unchanged and no second done follows.
- start held high for 40 cycles with A=3, B=5 → done pulses every 10 clocks with product=15; busy and done never overlap.
- rst asserted in the 5th RUN cycle → next cycle busy=0, done=0, product=0, state IDLE. A following start with A=7, B=9 yields 63 with normal latency.
- WIDTH=4 randomized: 200 random pairs checked against a reference A·B at each done; exhaustive 256 pairs for WIDTH=4.
